cmos_capture_roi: RTL and testbench
===================================

CMOS_CAPTURE_ROI -- requirements
Module: cmos_capture_roi

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_W, 8, sensor data bus width.
- BPP, 2, bytes per pixel; legal range 1..4.
- WAIT_FRAMES, 10, frames discarded after init before capture starts; range 0..15.
- DECIM, 1, emit one frame of every DECIM frames; range 1..16.
- X_START, 0, first emitted column.
- X_END, 639, last emitted column.
- Y_START, 0, first emitted row.
- Y_END, 479, last emitted row.
- VS_POL, 1, active level of cmos_vsync.
REQ-002 Ports SHALL be, one per line:
- clk, in, 1, sensor pixel clock; the only clock.
- rst_n, in, 1, asynchronous active-low reset.
- init_done, in, 1, sensor and SDRAM configuration complete.
- cmos_vsync, in, 1, sensor frame sync.
- cmos_href, in, 1, sensor line valid, active high.
- cmos_data, in, DATA_W, sensor byte.
- pix_data, out, DATA_W*BPP, assembled pixel; first byte received is the MSB.
- pix_valid, out, 1, pix_data valid for one cycle.
- out_vsync, out, 1, active-high frame window of an emitted frame.
- out_href, out, 1, active-high row window of an emitted ROI row.
- frame_start, out, 1, one-cycle pulse at the start of an emitted frame.
- frame_done, out, 1, one-cycle pulse at the end of an emitted frame.
- partial_err, out, 1, sticky flag: href fell mid-pixel.
- frame_cnt, out, 8, emitted-frame counter; wraps 255 to 0.

Function
REQ-003 cmos_vsync, cmos_href and cmos_data SHALL be registered once before any use.
REQ-004 Frame boundary SHALL be the registered vsync transition from VS_POL to !VS_POL.
REQ-005 FSM states and transitions SHALL be:
- IDLE to WAIT when init_done is high.
- WAIT to RUN after WAIT_FRAMES frame boundaries; if WAIT_FRAMES=0, WAIT to RUN at the first boundary.
- Any state to IDLE in the cycle after init_done goes low.
REQ-006 In RUN, a frame counter modulo DECIM SHALL advance at each boundary. A frame SHALL be emitted only when this counter is 0 at its starting boundary.
REQ-007 Byte counter:
- Counts 0..BPP-1 while registered href is high.
- The pixel completes on byte BPP-1.
- The counter clears on href low.
REQ-008 Column and row counters:
- The column counter (12 bits) increments per completed pixel and clears when href falls.
- The row counter (12 bits) increments on each href falling edge and clears at a frame boundary.
REQ-009 pix_valid SHALL assert only for a completed pixel of an emitted frame with X_START<=col<=X_END and Y_START<=row<=Y_END.
REQ-010 A pixel whose last byte is on cmos_data at clock edge N SHALL appear on pix_valid/pix_data at edge N+2.
REQ-011 out_href SHALL be high from the first to the last ROI pixel of a row, aligned with pix_valid.
REQ-012 out_vsync SHALL be high from frame_start through frame_done inclusive.
REQ-013 frame_start SHALL pulse one cycle after an emitting boundary.
REQ-014 frame_done SHALL pulse one cycle after the href falling edge of row Y_END. If the next boundary arrives first, frame_done SHALL pulse at that boundary instead.
REQ-015 frame_cnt SHALL increment on frame_done.
REQ-016 If href falls with byte counter nonzero, the partial pixel SHALL be discarded, the column counter SHALL NOT advance, and partial_err SHALL set. partial_err clears only on reset.
REQ-017 A frame boundary mid-row SHALL abort the row: counters clear and no pixel is emitted from the residue.
REQ-018 Outside IDLE-to-RUN emission, pix_valid, out_href, out_vsync, frame_start and frame_done SHALL be 0. pix_data SHALL hold its last value.
REQ-019 X_END<X_START or Y_END<Y_START SHALL yield no pix_valid, while frame_start and frame_done still pulse.

Reset
REQ-020 When rst_n is low, all outputs, counters and input registers SHALL be 0, and the FSM SHALL be IDLE, asynchronously.
REQ-021 After rst_n deasserts, the first action SHALL be the first clk edge sampling init_done.
REQ-022 A reset mid-frame SHALL discard that frame entirely. After release, capture SHALL again wait WAIT_FRAMES frames.

Verification
REQ-023 Defaults, 640x480 BPP=2 stimulus:
- Frames 1-10 yield no pix_valid.
- Frame 11 yields exactly 307200 pix_valid, bytes 0xAB then 0xCD give pix_data=0xABCD, and frame_cnt=1 after frame_done.
REQ-024 ROI X=100..199, Y=50..59: exactly 100 pix_valid per row over 10 rows (1000 total). The first pixel is col 100 of row 50.
REQ-025 DECIM=3, WAIT_FRAMES=0: frames 1, 4, 7 are emitted. frame_start count = 3 over 9 frames.
REQ-026 href drops after 3 bytes of a row (BPP=2): 1 pixel emitted, partial_err=1, and the next row starts at col 0.
REQ-027 init_done dropped mid-frame: pix_valid=0 within 1 cycle. On restore, 10 wait frames precede the next frame_start.
REQ-028 Latency: a last byte at edge N gives pix_valid at edge N+2. rst_n asserted asynchronously between edges forces all outputs to 0 immediately.

Source files
------------

// File: rtl/cmos_capture_roi.sv
// Capture a DVP-style CMOS sensor stream and emit a windowed, decimated pixel stream.
// Raw sensor pins are registered once; everything downstream runs off the registered copies.
module cmos_capture_roi #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned BPP         = 2,
    parameter int unsigned WAIT_FRAMES = 10,
    parameter int unsigned DECIM       = 1,
    parameter int unsigned X_START     = 0,
    parameter int unsigned X_END       = 639,
    parameter int unsigned Y_START     = 0,
    parameter int unsigned Y_END       = 479,
    parameter bit          VS_POL      = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    init_done,
    input  logic                    cmos_vsync,
    input  logic                    cmos_href,
    input  logic [DATA_W-1:0]       cmos_data,
    output logic [DATA_W*BPP-1:0]   pix_data,
    output logic                    pix_valid,
    output logic                    out_vsync,
    output logic                    out_href,
    output logic                    frame_start,
    output logic                    frame_done,
    output logic                    partial_err,
    output logic [7:0]              frame_cnt
);

    localparam int unsigned PIX_W      = DATA_W * BPP;
    localparam logic [1:0]  BYTE_LAST  = 2'(BPP - 1);
    localparam logic [3:0]  WAIT_LAST  = 4'((WAIT_FRAMES == 0) ? 0 : WAIT_FRAMES - 1);
    localparam logic [3:0]  DECIM_LAST = 4'(DECIM - 1);
    localparam logic [11:0] X_LO       = 12'(X_START);
    localparam logic [11:0] X_HI       = 12'(X_END);
    localparam logic [11:0] Y_LO       = 12'(Y_START);
    localparam logic [11:0] Y_HI       = 12'(Y_END);

    typedef enum logic [1:0] {StIdle, StWait, StRun} state_e;

    state_e state_q, state_d;

    logic              vs_q, vs_prev_q, href_q, href_prev_q;
    logic [DATA_W-1:0] data_q;
    logic              boundary, href_fall;
    logic              run_boundary, wait_tick;
    logic [3:0]        wait_cnt_q, dec_q;
    logic              emit_q, emit_d, emit_start, done_d;
    logic [1:0]        byte_cnt_q;
    logic [11:0]       col_q, row_q;
    logic [12:0]       col_p1, row_p1;
    logic              pix_last, in_roi, hit_d;
    logic [PIX_W-1:0]  shift_q, assembled, asm_q;
    logic              hit_q, hit_last_q, abort_q, open_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q        <= 1'b0;
            vs_prev_q   <= 1'b0;
            href_q      <= 1'b0;
            href_prev_q <= 1'b0;
            data_q      <= '0;
        end else begin
            vs_q        <= cmos_vsync;
            vs_prev_q   <= vs_q;
            href_q      <= cmos_href;
            href_prev_q <= href_q;
            data_q      <= cmos_data;
        end
    end

    assign boundary  = (vs_prev_q == VS_POL) && (vs_q != VS_POL);
    assign href_fall = href_prev_q && !href_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (init_done) state_d = StWait;
            StWait: if (boundary && (WAIT_FRAMES == 0 || wait_cnt_q == WAIT_LAST)) state_d = StRun;
            StRun:  state_d = StRun;
            default: state_d = StIdle;
        endcase
        if (!init_done) state_d = StIdle;
    end

    // With no wait frames the boundary that leaves WAIT already starts frame 1.
    always_comb begin
        run_boundary = 1'b0;
        wait_tick    = 1'b0;
        unique case (state_q)
            StWait: begin
                wait_tick    = boundary;
                run_boundary = boundary && (WAIT_FRAMES == 0);
            end
            StRun:   run_boundary = boundary;
            default: run_boundary = 1'b0;
        endcase
        run_boundary = run_boundary && init_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            dec_q      <= '0;
        end else begin
            if (state_q != StWait) wait_cnt_q <= '0;
            else if (wait_tick)    wait_cnt_q <= wait_cnt_q + 4'd1;
            if (state_q == StIdle)  dec_q <= '0;
            else if (run_boundary) dec_q <= (dec_q == DECIM_LAST) ? 4'd0 : dec_q + 4'd1;
        end
    end

    assign emit_start = run_boundary && (dec_q == 4'd0);
    // A boundary while still emitting closes the frame early.
    assign done_d = emit_q && init_done && (boundary || (href_fall && row_q == Y_HI));

    always_comb begin
        emit_d = emit_q;
        if (!init_done)      emit_d = 1'b0;
        else if (emit_start) emit_d = 1'b1;
        else if (done_d)     emit_d = 1'b0;
    end

    assign col_p1    = {1'b0, col_q} + 13'd1;
    assign row_p1    = {1'b0, row_q} + 13'd1;
    assign in_roi    = (col_p1 > {1'b0, X_LO}) && (col_q <= X_HI) &&
                       (row_p1 > {1'b0, Y_LO}) && (row_q <= Y_HI);
    assign pix_last  = href_q && (byte_cnt_q == BYTE_LAST);
    assign hit_d     = pix_last && !boundary && emit_q && init_done && in_roi;
    assign assembled = (shift_q << DATA_W) | PIX_W'(data_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q  <= '0;
            col_q       <= '0;
            row_q       <= '0;
            shift_q     <= '0;
            asm_q       <= '0;
            hit_q       <= 1'b0;
            hit_last_q  <= 1'b0;
            abort_q     <= 1'b0;
            partial_err <= 1'b0;
        end else begin
            if (boundary || !href_q) begin
                byte_cnt_q <= '0;
                col_q      <= '0;
            end else if (pix_last) begin
                byte_cnt_q <= '0;
                col_q      <= col_q + 12'd1;
            end else begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end
            if (boundary)       row_q <= '0;
            else if (href_fall) row_q <= row_q + 12'd1;
            if (href_q) shift_q <= assembled;
            if (hit_d)  asm_q   <= assembled;
            hit_q      <= hit_d;
            hit_last_q <= hit_d && (col_q == X_HI);
            abort_q    <= !href_q || boundary || !init_done;
            if (href_fall && byte_cnt_q != 2'd0) partial_err <= 1'b1;
        end
    end

    // open_q bridges the byte gaps between ROI pixels so out_href stays high across the row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            out_href    <= 1'b0;
            open_q      <= 1'b0;
            emit_q      <= 1'b0;
            out_vsync   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            pix_valid <= hit_q && init_done;
            if (hit_q && init_done) pix_data <= asm_q;
            out_href    <= init_done && (hit_q || (open_q && !abort_q));
            open_q      <= init_done && (hit_q ? !hit_last_q : (open_q && !abort_q));
            emit_q      <= emit_d;
            out_vsync   <= emit_d || done_d;
            frame_start <= emit_start;
            frame_done  <= done_d;
            if (done_d) frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_cmos_capture_roi.sv
// Directed bench for cmos_capture_roi on a small 6x4-pixel sensor frame.
// Main instance: ROI cols 2..4 rows 1..2; second instance: DECIM=3, no wait, empty X window.
module tb_cmos_capture_roi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_done;
    logic        cmos_vsync;
    logic        cmos_href;
    logic [7:0]  cmos_data;

    logic [15:0] pix_data, pix_data2;
    logic        pix_valid, out_vsync, out_href, frame_start, frame_done, partial_err;
    logic        pix_valid2, out_vsync2, out_href2, frame_start2, frame_done2, partial_err2;
    logic [7:0]  frame_cnt, frame_cnt2;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int pv = 0, oh = 0, fs = 0, fd = 0, vs_bad = 0;
    int pv2 = 0, fs2 = 0, fd2 = 0;
    int first_pv = -1;
    int lat_exp  = -2;
    bit lat_arm  = 1'b0;
    int pv0, fs0;
    logic [15:0] pq[$];

    cmos_capture_roi #(
        .DATA_W(8), .BPP(2), .WAIT_FRAMES(2), .DECIM(1),
        .X_START(2), .X_END(4), .Y_START(1), .Y_END(2), .VS_POL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_data(cmos_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .out_vsync(out_vsync),
        .out_href(out_href), .frame_start(frame_start), .frame_done(frame_done),
        .partial_err(partial_err), .frame_cnt(frame_cnt)
    );

    cmos_capture_roi #(
        .DATA_W(8), .BPP(2), .WAIT_FRAMES(0), .DECIM(3),
        .X_START(5), .X_END(1), .Y_START(0), .Y_END(3), .VS_POL(1'b1)
    ) dut_dec (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_data(cmos_data),
        .pix_data(pix_data2), .pix_valid(pix_valid2), .out_vsync(out_vsync2),
        .out_href(out_href2), .frame_start(frame_start2), .frame_done(frame_done2),
        .partial_err(partial_err2), .frame_cnt(frame_cnt2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pix_valid) begin
            pv++;
            pq.push_back(pix_data);
            if (first_pv < 0) first_pv = cyc;
        end
        if (out_href) oh++;
        if (frame_start) fs++;
        if (frame_done) fd++;
        if ((frame_start || frame_done || pix_valid || out_href) && !out_vsync) vs_bad++;
        if (pix_valid2) pv2++;
        if (frame_start2) fs2++;
        if (frame_done2) fd2++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic vsync_pulse();
        cmos_vsync = 1'b1;
        idle(3);
        cmos_vsync = 1'b0;
        idle(3);
    endtask

    // Byte pattern: even bytes carry 0xA0+row, odd bytes 0xB0+col.
    task automatic send_row(input int r, input int nbytes, input int drop_at);
        for (int b = 0; b < nbytes; b++) begin
            if (b == drop_at) begin
                check_val("vsync_before_drop", {31'd0, out_vsync}, 32'd1);
                init_done = 1'b0;
            end
            cmos_href = 1'b1;
            cmos_data = (b % 2 == 0) ? 8'(8'hA0 + r) : 8'(8'hB0 + b / 2);
            if (lat_arm && r == 1 && b == 5) begin
                lat_exp = cyc + 3;
                lat_arm = 1'b0;
            end
            tick();
            if (b == drop_at) begin
                check_val("pv_after_drop", {31'd0, pix_valid}, 32'd0);
                check_val("vsync_after_drop", {31'd0, out_vsync}, 32'd0);
            end
        end
        cmos_href = 1'b0;
        cmos_data = 8'h00;
        idle(4);
    endtask

    task automatic run_frame(input int drop_row, input int drop_byte,
                             input int short_row, input int short_len);
        vsync_pulse();
        for (int r = 0; r < 4; r++)
            send_row(r, (r == short_row) ? short_len : 12, (r == drop_row) ? drop_byte : -1);
        idle(4);
    endtask

    initial begin
        rst_n      = 1'b0;
        init_done  = 1'b0;
        cmos_vsync = 1'b0;
        cmos_href  = 1'b0;
        cmos_data  = 8'h00;
        idle(3);
        check_val("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
        check_val("rst_out_vsync", {31'd0, out_vsync}, 32'd0);
        check_val("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        check_val("rst_pix_data", {16'd0, pix_data}, 32'd0);
        init_done = 1'b1;
        rst_n     = 1'b1;
        idle(3);

        // Frames 1-2 are wait frames for the main instance.
        run_frame(-1, -1, -1, 0);
        run_frame(-1, -1, -1, 0);
        check_val("wait_no_pix", pv, 0);
        check_val("wait_no_start", fs, 0);

        pq.delete();
        lat_arm = 1'b1;
        run_frame(-1, -1, -1, 0);
        check_val("f3_pix_count", pv, 6);
        check_val("f3_latency", first_pv, lat_exp);
        check_val("f3_first_pix", {16'd0, pq[0]}, 32'h0000A1B2);
        check_val("f3_last_pix", {16'd0, pq[5]}, 32'h0000A2B4);
        check_val("f3_href_cycles", oh, 10);
        check_val("f3_start", fs, 1);
        check_val("f3_done", fd, 1);
        check_val("f3_frame_cnt", {24'd0, frame_cnt}, 32'd1);

        for (int f = 4; f <= 9; f++) run_frame(-1, -1, -1, 0);
        check_val("f9_pix_count", pv, 42);
        check_val("f9_frame_cnt", {24'd0, frame_cnt}, 32'd7);
        check_val("no_partial_yet", {31'd0, partial_err}, 32'd0);
        check_val("decim_starts", fs2, 3);
        check_val("decim_dones", fd2, 3);
        check_val("decim_frame_cnt", {24'd0, frame_cnt2}, 32'd3);
        check_val("empty_roi_no_pix", pv2, 0);

        // Row 1 is cut after 7 bytes: one pixel in, one partial byte thrown away.
        pv0 = pv;
        pq.delete();
        run_frame(-1, -1, 1, 7);
        check_val("partial_pix_count", pv - pv0, 4);
        check_val("partial_kept_pix", {16'd0, pq[0]}, 32'h0000A1B2);
        check_val("next_row_col0", {16'd0, pq[1]}, 32'h0000A2B2);
        check_val("partial_err_set", {31'd0, partial_err}, 32'd1);

        // init_done drops just after col 2 of row 1 is fully on the bus.
        pv0 = pv;
        run_frame(1, 6, -1, 0);
        check_val("drop_no_pix", pv - pv0, 0);
        init_done = 1'b1;
        idle(2);
        fs0 = fs;
        pv0 = pv;
        run_frame(-1, -1, -1, 0);
        run_frame(-1, -1, -1, 0);
        check_val("rewait_no_start", fs - fs0, 0);
        run_frame(-1, -1, -1, 0);
        check_val("rewait_start", fs - fs0, 1);
        check_val("rewait_pix", pv - pv0, 6);
        check_val("pre_rst_frame_cnt", {24'd0, frame_cnt}, 32'd9);
        check_val("sticky_partial", {31'd0, partial_err}, 32'd1);

        // Asynchronous reset in the middle of an emitted frame.
        vsync_pulse();
        send_row(0, 12, -1);
        send_row(1, 12, -1);
        check_val("pre_rst_vsync", {31'd0, out_vsync}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_vsync", {31'd0, out_vsync}, 32'd0);
        check_val("async_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        check_val("async_partial", {31'd0, partial_err}, 32'd0);
        check_val("async_pix_data", {16'd0, pix_data}, 32'd0);
        tick();
        rst_n = 1'b1;
        pv0 = pv;
        fs0 = fs;
        send_row(2, 12, -1);
        send_row(3, 12, -1);
        idle(4);
        run_frame(-1, -1, -1, 0);
        run_frame(-1, -1, -1, 0);
        check_val("post_rst_no_pix", pv - pv0, 0);
        check_val("post_rst_no_start", fs - fs0, 0);
        run_frame(-1, -1, -1, 0);
        check_val("post_rst_start", fs - fs0, 1);
        check_val("post_rst_frame_cnt", {24'd0, frame_cnt}, 32'd1);
        check_val("vsync_window", vs_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
